// File: rtl/e1b_code_capture_pkg.sv
// Shared constants and types for the E1B code capture buffer.
// Op bit indices sit alongside SET_E1B_CODE on the CPU command bus.
package e1b_code_capture_pkg;

    localparam int unsigned SET_E1B_CAP = 6;
    localparam int unsigned GET_E1B_CAP = 7;
    localparam int unsigned E1B_CAP_AW  = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/cap_ram_256x16.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Only the read register is reset; array contents survive reset.
module cap_ram_256x16 #(
    parameter int unsigned NWORDS = 256,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned AW     = $clog2(NWORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [NWORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking write above makes a same-address read return the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/e1b_code_capture.sv
// Serial-in capture buffer: packs bit_vld-strobed bits LSB-first into 16-bit
// words, CPU reads them back one word per GET_E1B_CAP strobe.
module e1b_code_capture
    import e1b_code_capture_pkg::*;
#(
    parameter int unsigned NWORDS = 256,
    parameter int unsigned WORD_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrReg,
    input  logic        rdReg,
    input  logic [15:0] op,
    input  logic [31:0] tos,
    input  logic        bit_vld,
    input  logic        bit_in,
    output logic [15:0] dout,
    output logic [15:0] status
);

    localparam int unsigned AW = $clog2(NWORDS);

    cap_state_e        state;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [AW-1:0]     len;
    logic [3:0]        bitcnt;
    logic [AW:0]       wcount;
    logic [WORD_W-2:0] shreg;

    logic              arm;
    logic              rd_stb;
    logic              take_bit;
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic              unused_bits;

    assign arm      = wrReg && op[SET_E1B_CAP];
    assign rd_stb   = rdReg && op[GET_E1B_CAP];
    // Arm has priority, so a coincident bit is dropped.
    assign take_bit = (state == StCapture) && bit_vld && !arm;
    assign we       = take_bit && (bitcnt == 4'd15);
    assign wdata    = {bit_in, shreg};

    assign unused_bits = ^{tos[31:AW], op};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            waddr  <= '0;
            raddr  <= '0;
            len    <= '0;
            bitcnt <= '0;
            wcount <= '0;
            shreg  <= '0;
        end else if (arm) begin
            state  <= StCapture;
            len    <= tos[AW-1:0];
            waddr  <= '0;
            raddr  <= '0;
            bitcnt <= '0;
            wcount <= '0;
            shreg  <= '0;
        end else begin
            if (rd_stb) begin
                raddr <= raddr + 1'b1;
            end
            if (take_bit) begin
                if (bitcnt == 4'd15) begin
                    bitcnt <= '0;
                    waddr  <= waddr + 1'b1;
                    wcount <= wcount + 1'b1;
                    if (waddr == len) begin
                        state <= StDone;
                    end
                end else begin
                    shreg[bitcnt] <= bit_in;
                    bitcnt        <= bitcnt + 1'b1;
                end
            end
        end
    end

    cap_ram_256x16 #(
        .NWORDS (NWORDS),
        .WORD_W (WORD_W),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (dout)
    );

    always_comb begin
        status = {state == StDone, state == StCapture, bitcnt, 1'b0, wcount};
    end

endmodule

// File: tb/tb_e1b_code_capture.sv
// Directed bench for e1b_code_capture with hand-computed expected values.
module tb_e1b_code_capture;
    import e1b_code_capture_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrReg = 1'b0;
    logic        rdReg = 1'b0;
    logic [15:0] op = '0;
    logic [31:0] tos = '0;
    logic        bit_vld = 1'b0;
    logic        bit_in = 1'b0;
    logic [15:0] dout;
    logic [15:0] status;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] model [256];

    always #5 clk = ~clk;

    e1b_code_capture dut (
        .clk     (clk),
        .rst     (rst),
        .wrReg   (wrReg),
        .rdReg   (rdReg),
        .op      (op),
        .tos     (tos),
        .bit_vld (bit_vld),
        .bit_in  (bit_in),
        .dout    (dout),
        .status  (status)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic arm(input logic [7:0] l, input logic with_bit, input logic with_rd);
        @(negedge clk);
        wrReg = 1'b1;
        op = 16'(1 << SET_E1B_CAP);
        if (with_rd) begin
            rdReg = 1'b1;
            op = op | 16'(1 << GET_E1B_CAP);
        end
        tos = {24'h0, l};
        bit_vld = with_bit;
        bit_in = with_bit;
        @(negedge clk);
        wrReg = 1'b0;
        rdReg = 1'b0;
        op = '0;
        tos = '0;
        bit_vld = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_vld = 1'b1;
        bit_in = b;
        @(negedge clk);
        bit_vld = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) send_bit(w[i]);
    endtask

    // Strobe, then wait one extra clk so dout reflects the advanced pointer.
    task automatic rd_strobe();
        @(negedge clk);
        rdReg = 1'b1;
        op = 16'(1 << GET_E1B_CAP);
        @(negedge clk);
        rdReg = 1'b0;
        op = '0;
        @(negedge clk);
    endtask

    initial begin
        // 1: reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_dout", dout, 16'h0000);
        check("reset_status", status, 16'h0000);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check("idle_bits_ignored", status, 16'h0000);

        // 2: two words
        arm(8'h01, 1'b0, 1'b0);
        check("armed_status", status, 16'h4000);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check("bitcnt3_status", status, 16'h4C00);
        for (int i = 3; i < 16; i++) send_bit(1'b0);
        check("one_word_status", status, 16'h4001);
        send_word(16'hA5C3);
        check("two_word_done", status, 16'h8002);
        check("rd_word0", dout, 16'h0001);
        rd_strobe();
        check("rd_word1", dout, 16'hA5C3);

        // 3: partial word discarded on re-arm
        arm(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        check("partial_status", status, 16'h6000);
        arm(8'h00, 1'b0, 1'b0);
        check("rearm_status", status, 16'h4000);
        send_word(16'hFFFF);
        check("rearm_done", status, 16'h8001);
        send_bit(1'b1);
        check("done_bits_ignored", status, 16'h8001);
        check("rearm_word0", dout, 16'hFFFF);
        rd_strobe();
        check("word1_untouched", dout, 16'hA5C3);

        // 4: full 256-word capture
        for (int i = 0; i < 256; i++) model[i] = 16'($urandom);
        arm(8'hFF, 1'b0, 1'b0);
        for (int w = 0; w < 256; w++) begin
            for (int b = 0; b < 16; b++) begin
                if (w == 255 && b == 15)
                    check("full_almost_status", status, 16'h7CFF);
                send_bit(model[w][b]);
            end
        end
        check("full_done_status", status, 16'h8100);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("full_rd%0d", i), dout, model[i]);
            rd_strobe();
        end
        check("full_rd_wrap", dout, model[0]);

        // 5: arm with coincident bit drops the bit; read-first on write
        arm(8'h00, 1'b1, 1'b0);
        check("arm_bit_dropped", status, 16'h4000);
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        send_bit(1'b0);
        check("read_first_old", dout, model[0]);
        @(negedge clk);
        check("arm_bit_word0", dout, 16'h0000);
        check("arm_bit_done", status, 16'h8001);
        rd_strobe();
        check("adv_to_word1", dout, model[1]);
        arm(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("arm_rd_raddr0", dout, 16'h0000);

        // 6: async reset mid-capture
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("pre_reset_status", status, 16'h5C00);
        #2 rst = 1'b1;
        #1;
        check("async_rst_status", status, 16'h0000);
        check("async_rst_dout", dout, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        check("post_reset_ignored", status, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
